// File: rtl/vc_output_arbiter_if.sv
// vc_output_arbiter_if: VC arbiter handshake bundle (per-VC valid/grant, head packet in, registered packet out)
interface vc_output_arbiter_if #(
  parameter int M = 4,
  parameter int W = 8
);
  logic [W-1:0] i_data;
  logic [0:M-1] i_data_val;
  logic [0:M-1] o_en;
  logic [W-1:0] o_data;
  logic         o_data_val;
  logic         i_en;
  modport master (output i_data, i_data_val, i_en, input o_en, o_data, o_data_val);
  modport slave  (input i_data, i_data_val, i_en, output o_en, o_data, o_data_val);
endinterface

// File: rtl/vc_output_arbiter.sv
// vc_output_arbiter: round-robin VC arbiter with a registered single-entry output slot.
// Define VC_ARB_HOLD_EN to let a winning VC keep the grant for up to HOLD consecutive packets.
module vc_output_arbiter #(
  parameter int M    = 4,
  parameter int HOLD = 4,
  parameter int W    = 8
) (
  input logic             clk,
  input logic             reset_n,
  vc_output_arbiter_if.slave bus
);
  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = $clog2(HOLD + 1);
`ifdef VC_ARB_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  logic [PW-1:0] ptr, last, rr_idx, sel;
  logic [CW-1:0] cnt;
  logic          last_val, accept, grant, hold_ok;
  assign accept  = !bus.o_data_val || bus.i_en;
  assign grant   = reset_n && accept && (|bus.i_data_val);
  assign hold_ok = HOLD_EN && last_val && bus.i_data_val[last] && (cnt < CW'(HOLD));
  assign sel     = hold_ok ? last : rr_idx;
  always_comb begin
    logic [PW-1:0] k;
    logic          found;
    found  = 1'b0;
    rr_idx = '0;
    k      = '0;
    for (int j = 0; j < M; j++) begin
      k = PW'((int'(ptr) + j) % M);
      if (!found && bus.i_data_val[k]) begin
        found  = 1'b1;
        rr_idx = k;
      end
    end
  end
  always_comb begin
    bus.o_en = '0;
    if (grant) bus.o_en[sel] = 1'b1;
  end
  // a grant both refills the slot and drains the old packet, so no bubble at full rate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.o_data     <= '0;
      bus.o_data_val <= 1'b0;
      ptr            <= '0;
      last           <= '0;
      last_val       <= 1'b0;
      cnt            <= '0;
    end else if (grant) begin
      bus.o_data     <= bus.i_data;
      bus.o_data_val <= 1'b1;
      ptr            <= (sel == PW'(M - 1)) ? '0 : sel + 1'b1;
      last           <= sel;
      last_val       <= 1'b1;
      cnt            <= hold_ok ? cnt + 1'b1 : CW'(1);
    end else if (accept) begin
      bus.o_data_val <= 1'b0;
      last_val       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vc_output_arbiter.sv
// tb_vc_output_arbiter: directed stimulus with a packet scoreboard drained by an output monitor.
module tb_vc_output_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_q[$];
  logic [5:0] seq[4] = '{default: '0};
  logic [7:0] ovr = 8'h00;
  logic       ovr_en = 1'b0;
  vc_output_arbiter_if #(.M(4), .W(8)) bus ();
  vc_output_arbiter #(.M(4), .HOLD(4), .W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
`ifdef VC_ARB_HOLD_EN
  localparam logic [3:0] FAIR_EN [8] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h4, 4'h4, 4'h4, 4'h4};
  localparam logic [7:0] FAIR_D  [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h41, 8'h42, 8'h43};
  localparam logic [7:0] D_ST0 = 8'h04, D_ST1 = 8'h44, D_W0 = 8'h80, D_W1 = 8'hC0, D_W2 = 8'hC1, D_MID = 8'h06;
  localparam logic [3:0] EN_W2 = 4'h1;
`else
  localparam logic [3:0] FAIR_EN [8] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1};
  localparam logic [7:0] FAIR_D  [8] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01, 8'h41, 8'h81, 8'hC1};
  localparam logic [7:0] D_ST0 = 8'h02, D_ST1 = 8'h42, D_W0 = 8'h82, D_W1 = 8'hC2, D_W2 = 8'h03, D_MID = 8'h05;
  localparam logic [3:0] EN_W2 = 4'h8;
`endif
  // upstream VC buffers: FWFT head muxed by the grant, X when nothing is granted
  always_comb begin
    bus.i_data = 'x;
    for (int v = 0; v < 4; v++)
      if (bus.o_en[v]) bus.i_data = ovr_en ? ovr : {2'(v), seq[v]};
  end
  always @(posedge clk)
    for (int v = 0; v < 4; v++)
      if (bus.o_en[v]) seq[v] <= seq[v] + 1'b1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (reset_n && bus.o_data_val && bus.i_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pkt: got %0h expected none", bus.o_data);
      end else chk("pkt", 32'(bus.o_data), 32'(exp_q.pop_front()));
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.i_data_val = 4'b1111;
    bus.i_en = 1'b1;
    #2;
    chk("reset_en", 32'(bus.o_en), 0);
    chk("reset_val", 32'(bus.o_data_val), 0);
    chk("reset_data", 32'(bus.o_data), 0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fair_en", 32'(bus.o_en), 32'(FAIR_EN[i]));
      exp_q.push_back(FAIR_D[i]);
      if (i > 0) chk("fair_val", 32'(bus.o_data_val), 1);
      step();
    end
    bus.i_data_val = 4'b0000;
    step();
    step();
    chk("idle_val", 32'(bus.o_data_val), 0);
    bus.i_data_val = 4'b1000;
    bus.i_en = 1'b0;
    #1;
    chk("stall_pre_en", 32'(bus.o_en), 32'h8);
    exp_q.push_back(D_ST0);
    step();
    bus.i_data_val = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_en", 32'(bus.o_en), 0);
      chk("stall_data", 32'(bus.o_data), 32'(D_ST0));
      chk("stall_val", 32'(bus.o_data_val), 1);
      step();
    end
    bus.i_en = 1'b1;
    #1;
    chk("unstall_en", 32'(bus.o_en), 32'h4);
    exp_q.push_back(D_ST1);
    step();
    bus.i_data_val = 4'b0000;
    #1;
    chk("unstall_val", 32'(bus.o_data_val), 1);
    step();
    step();
    bus.i_data_val = 4'b0010;
    #1;
    chk("wrap_setup_en", 32'(bus.o_en), 32'h2);
    exp_q.push_back(D_W0);
    step();
    bus.i_data_val = 4'b1001;
    #1;
    chk("wrap_en0", 32'(bus.o_en), 32'h1);
    exp_q.push_back(D_W1);
    step();
    #1;
    chk("wrap_en1", 32'(bus.o_en), 32'(EN_W2));
    exp_q.push_back(D_W2);
    step();
    bus.i_data_val = 4'b0000;
    step();
    step();
    ovr_en = 1'b1;
    ovr = 8'hA5;
    bus.i_data_val = 4'b0010;
    #1;
    chk("drain_en", 32'(bus.o_en), 32'h2);
    exp_q.push_back(8'hA5);
    step();
    bus.i_data_val = 4'b0000;
    ovr_en = 1'b0;
    #1;
    chk("drain_val1", 32'(bus.o_data_val), 1);
    chk("drain_data1", 32'(bus.o_data), 32'hA5);
    step();
    #1;
    chk("drain_val0", 32'(bus.o_data_val), 0);
    chk("drain_hold", 32'(bus.o_data), 32'hA5);
    bus.i_data_val = 4'b1000;
    bus.i_en = 1'b0;
    step();
    chk("mid_pre_val", 32'(bus.o_data_val), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_val", 32'(bus.o_data_val), 0);
    chk("mid_data", 32'(bus.o_data), 0);
    chk("mid_en", 32'(bus.o_en), 0);
    step();
    reset_n = 1'b1;
    bus.i_data_val = 4'b1111;
    bus.i_en = 1'b1;
    #1;
    chk("post_reset_en", 32'(bus.o_en), 32'h8);
    exp_q.push_back(D_MID);
    step();
    bus.i_data_val = 4'b0000;
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
